i_serdes_word_align: RTL and testbench
======================================

I_SERDES_WORD_ALIGN -- requirements
Module: i_serdes_word_align

Interface
REQ-001 Parameter WIDTH, default 4, deserialized word width, legal 3..10.
REQ-002 Parameter TRAIN_PATTERN, default 4'b0011, WIDTH-bit training word expected after alignment.
REQ-003 Parameter LOCK_COUNT, default 8, consecutive matching valid words required to declare lock, legal 1..255.
REQ-004 Parameter SLIP_WAIT, default 4, settle cycles after each BITSLIP_ADJ pulse, legal 1..15.
REQ-005 CLK_IN  input  1  single clock; all logic on its rising edge.
REQ-006 RST  input  1  reset, synchronous, active-high.
REQ-007 Q_IN  input  WIDTH  parallel word from the I_SERDES Q output.
REQ-008 DATA_VALID_IN  input  1  Q_IN qualifier, from the I_SERDES DATA_VALID output.
REQ-009 TRAIN_EN  input  1  level; high requests or maintains training, and its rising edge restarts training.
REQ-010 BITSLIP_ADJ  output  1  one-cycle slip request to the I_SERDES BITSLIP_ADJ input.
REQ-011 DATA_OUT  output  WIDTH  registered copy of Q_IN.
REQ-012 DATA_VALID_OUT  output  1  registered DATA_VALID_IN gated by ALIGNED.
REQ-013 ALIGNED  output  1  lock achieved.
REQ-014 ALIGN_ERROR  output  1  WIDTH slips attempted without lock.
REQ-015 SLIP_CNT  output  $clog2(WIDTH+1)  slips issued since training start.

Function
REQ-016 The FSM SHALL have the states IDLE, CHECK, SLIP, WAIT, LOCKED and FAIL, and all outputs SHALL be registered.
REQ-017 IDLE: a TRAIN_EN rising edge SHALL go to CHECK and clear the match counter and SLIP_CNT.
REQ-018 CHECK: each DATA_VALID_IN=1 word equal to TRAIN_PATTERN SHALL increment the match counter, and the LOCK_COUNTth consecutive match SHALL go to LOCKED.
REQ-019 CHECK: a valid mismatching word SHALL clear the match counter and go to SLIP if SLIP_CNT<WIDTH, else to FAIL.
REQ-020 CHECK: cycles with DATA_VALID_IN=0 SHALL hold the match counter and the state.
REQ-021 SLIP: BITSLIP_ADJ=1 for exactly one cycle, SLIP_CNT incremented, then WAIT.
REQ-022 WAIT: Q_IN SHALL be ignored for SLIP_WAIT cycles, then CHECK.
REQ-023 LOCKED: ALIGNED=1 from the cycle after the final matching word is sampled, held until RST or a TRAIN_EN rising edge.
REQ-024 FAIL: ALIGN_ERROR=1 and BITSLIP_ADJ=0, held until RST or a TRAIN_EN rising edge.
REQ-025 A TRAIN_EN rising edge in LOCKED or FAIL SHALL go to CHECK with ALIGNED, ALIGN_ERROR, SLIP_CNT and the match counter cleared.
REQ-026 TRAIN_EN=0 in CHECK, SLIP or WAIT SHALL return to IDLE, with no BITSLIP_ADJ pulse that cycle and SLIP_CNT held.
REQ-027 DATA_OUT SHALL load Q_IN when DATA_VALID_IN=1 (1-cycle latency) and otherwise hold.
REQ-028 DATA_VALID_OUT SHALL equal DATA_VALID_IN delayed 1 cycle AND ALIGNED.
REQ-029 SLIP_CNT SHALL saturate at WIDTH and never wrap.

Reset
REQ-030 RST=1 SHALL force IDLE and zero all outputs, the match counter, the WAIT counter and the TRAIN_EN edge register on the next edge, in any state.

Configuration
REQ-031 With I_SERDES_WORD_ALIGN_RELOCK_EN defined, a valid non-pattern word in LOCKED while TRAIN_EN=1 SHALL clear ALIGNED and go to CHECK.
REQ-032 Without I_SERDES_WORD_ALIGN_RELOCK_EN, LOCKED SHALL ignore Q_IN content.

Structure
REQ-033 Package i_serdes_align_pkg SHALL hold the state enum and the SLIP_CNT/match-counter width constants.
REQ-034 No sub-module is required; FSM and counters SHALL be inline.

Verification
REQ-035 WIDTH=4 with 8 valid words of 0011 under TRAIN_EN=1 -> ALIGNED=1 the cycle after word 8, no BITSLIP_ADJ pulses, SLIP_CNT=0.
REQ-036 Bench model rotating Q_IN by one bit per slip, starting at 1100 -> 2 single-cycle pulses at least 5 cycles apart, then lock with SLIP_CNT=2.
REQ-037 Constant 0000 input -> 4 pulses, then ALIGN_ERROR=1, ALIGNED=0, no fifth pulse; a TRAIN_EN re-rise clears ALIGN_ERROR.
REQ-038 DATA_VALID_IN low for 3 cycles between matches -> match count held, lock after the 8th valid match.
REQ-039 RST=1 in WAIT -> next cycle all outputs 0 and state IDLE.
REQ-040 In LOCKED, word 0101 with TRAIN_EN=1 -> ALIGNED falls next cycle with the macro defined, stays 1 without it.

Source files
------------

// File: rtl/i_serdes_align_pkg.sv
// -----------------------------------------------------------------------------
// i_serdes_align_pkg
// Shared types and widths for the I_SERDES word aligner.
//   align_state_e : aligner FSM states
//   MATCH_CNT_W   : width of the consecutive-match counter (LOCK_COUNT <= 255)
//   WAIT_CNT_W    : width of the post-slip settle counter (SLIP_WAIT <= 15)
//   slip_cnt_w()  : width of SLIP_CNT for a given word width
// -----------------------------------------------------------------------------
package i_serdes_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } align_state_e;

  localparam int MATCH_CNT_W = 8;
  localparam int WAIT_CNT_W  = 4;

  // SLIP_CNT must be able to hold the value WIDTH itself (saturation point).
  function automatic int slip_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/i_serdes_word_align.sv
// -----------------------------------------------------------------------------
// i_serdes_word_align
// Word aligner for an I_SERDES: compares deserialized words with a training
// pattern and issues BITSLIP_ADJ pulses until the pattern is seen LOCK_COUNT
// times in a row, or gives up after WIDTH slips.
//
// Ports
//   CLK_IN         in   single clock, rising edge
//   RST            in   synchronous active-high reset
//   Q_IN           in   [WIDTH] parallel word from the I_SERDES
//   DATA_VALID_IN  in   Q_IN qualifier
//   TRAIN_EN       in   level: keep training; rising edge restarts training
//   BITSLIP_ADJ    out  one-cycle slip request to the I_SERDES
//   DATA_OUT       out  [WIDTH] Q_IN captured on valid cycles
//   DATA_VALID_OUT out  DATA_VALID_IN delayed one cycle, gated by ALIGNED
//   ALIGNED        out  lock achieved
//   ALIGN_ERROR    out  WIDTH slips tried without lock
//   SLIP_CNT       out  [$clog2(WIDTH+1)] slips since training start
//
// Build option
//   I_SERDES_WORD_ALIGN_RELOCK_EN : when defined, a valid non-pattern word
//   while LOCKED and TRAIN_EN=1 drops lock and restarts checking.
// -----------------------------------------------------------------------------
module i_serdes_word_align
  import i_serdes_align_pkg::*;
#(
  parameter int                WIDTH         = 4,
  parameter logic [WIDTH-1:0]  TRAIN_PATTERN = WIDTH'(4'b0011),
  parameter int                LOCK_COUNT    = 8,
  parameter int                SLIP_WAIT     = 4
) (
  input  logic                          CLK_IN,
  input  logic                          RST,
  input  logic [WIDTH-1:0]              Q_IN,
  input  logic                          DATA_VALID_IN,
  input  logic                          TRAIN_EN,
  output logic                          BITSLIP_ADJ,
  output logic [WIDTH-1:0]              DATA_OUT,
  output logic                          DATA_VALID_OUT,
  output logic                          ALIGNED,
  output logic                          ALIGN_ERROR,
  output logic [slip_cnt_w(WIDTH)-1:0]  SLIP_CNT
);

  localparam int SCW = slip_cnt_w(WIDTH);

  localparam logic [SCW-1:0]         SLIP_MAX  = SCW'(WIDTH);
  localparam logic [MATCH_CNT_W-1:0] LOCK_LAST = MATCH_CNT_W'(LOCK_COUNT - 1);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_LAST = WAIT_CNT_W'(SLIP_WAIT - 1);

  align_state_e           state;
  logic [MATCH_CNT_W-1:0] match_cnt;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   train_q;

  logic train_rise;
  logic word_ok;
  logic lock_hit;
  logic relock_miss;
  logic aligned_nxt;

  // Decode shared by the FSM and by DATA_VALID_OUT: DATA_VALID_OUT must agree
  // with the ALIGNED value being registered on the same edge, so the next
  // value of ALIGNED is formed here once.
  always_comb begin
    train_rise = TRAIN_EN & ~train_q;
    word_ok    = DATA_VALID_IN & (Q_IN == TRAIN_PATTERN);
    lock_hit   = (state == ST_CHECK) & TRAIN_EN & word_ok & (match_cnt == LOCK_LAST);
`ifdef I_SERDES_WORD_ALIGN_RELOCK_EN
    relock_miss = TRAIN_EN & DATA_VALID_IN & ~word_ok;
`else
    relock_miss = 1'b0;
`endif
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    aligned_nxt = 1'b0;
    case (state)
      ST_CHECK:  aligned_nxt = lock_hit;
      ST_LOCKED: aligned_nxt = ~train_rise & ~relock_miss;
      default:   aligned_nxt = 1'b0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_IN) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch.
    if (RST) begin
      state          <= ST_IDLE;
      match_cnt      <= '0;
      wait_cnt       <= '0;
      train_q        <= 1'b0;
      BITSLIP_ADJ    <= 1'b0;
      DATA_OUT       <= '0;
      DATA_VALID_OUT <= 1'b0;
      ALIGNED        <= 1'b0;
      ALIGN_ERROR    <= 1'b0;
      SLIP_CNT       <= '0;
    end else begin
      train_q        <= TRAIN_EN;
      ALIGNED        <= aligned_nxt;
      DATA_VALID_OUT <= DATA_VALID_IN & aligned_nxt;
      BITSLIP_ADJ    <= 1'b0;
      if (DATA_VALID_IN) begin
        DATA_OUT <= Q_IN;
      end

      case (state)
        ST_IDLE: begin
          if (train_rise) begin
            state     <= ST_CHECK;
            match_cnt <= '0;
            SLIP_CNT  <= '0;
          end
        end

        ST_CHECK: begin
          if (!TRAIN_EN) begin
            state <= ST_IDLE;
          end else if (word_ok) begin
            if (lock_hit) begin
              state <= ST_LOCKED;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else if (DATA_VALID_IN) begin
            match_cnt <= '0;
            if (SLIP_CNT < SLIP_MAX) begin
              state <= ST_SLIP;
            end else begin
              state       <= ST_FAIL;
              ALIGN_ERROR <= 1'b1;
            end
          end
        end

        // The pulse is registered here so that dropping TRAIN_EN while in
        // SLIP suppresses it and leaves SLIP_CNT untouched.
        ST_SLIP: begin
          if (!TRAIN_EN) begin
            state <= ST_IDLE;
          end else begin
            BITSLIP_ADJ <= 1'b1;
            if (SLIP_CNT != SLIP_MAX) begin
              SLIP_CNT <= SLIP_CNT + 1'b1;
            end
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end

        // Q_IN is ignored while the I_SERDES settles after a slip.
        ST_WAIT: begin
          if (!TRAIN_EN) begin
            state <= ST_IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (train_rise || relock_miss) begin
            state     <= ST_CHECK;
            match_cnt <= '0;
            if (train_rise) begin
              SLIP_CNT <= '0;
            end
          end
        end

        ST_FAIL: begin
          if (train_rise) begin
            state       <= ST_CHECK;
            match_cnt   <= '0;
            SLIP_CNT    <= '0;
            ALIGN_ERROR <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_serdes_word_align.sv
// -----------------------------------------------------------------------------
// tb_i_serdes_word_align
// Self-checking bench for i_serdes_word_align (WIDTH=4, pattern 0011,
// LOCK_COUNT=8, SLIP_WAIT=4). A vector table covers lock, valid gaps and the
// locked-mismatch behaviour; hand-written sequences cover slipping, failure,
// reset in WAIT and training abort. DATA_OUT is tracked by a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_i_serdes_word_align;

`ifdef I_SERDES_WORD_ALIGN_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q_in;
  logic       dv_in;
  logic       train_en;
  logic       bitslip;
  logic [3:0] data_out;
  logic       dv_out;
  logic       aligned;
  logic       align_error;
  logic [2:0] slip_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb[$];
  logic [3:0] exp_data;

  always #5 clk = ~clk;

  i_serdes_word_align dut (
    .CLK_IN        (clk),
    .RST           (rst),
    .Q_IN          (q_in),
    .DATA_VALID_IN (dv_in),
    .TRAIN_EN      (train_en),
    .BITSLIP_ADJ   (bitslip),
    .DATA_OUT      (data_out),
    .DATA_VALID_OUT(dv_out),
    .ALIGNED       (aligned),
    .ALIGN_ERROR   (align_error),
    .SLIP_CNT      (slip_cnt)
  );

  typedef struct {
    logic       rst;
    logic       te;
    logic       dv;
    logic [3:0] q;
    logic       aligned;
    logic       slip;
    logic       err;
    logic [2:0] scnt;
    logic       dvo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare DATA_OUT with the
  // scoreboard. Outputs are sampled 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic t, input logic d, input logic [3:0] q);
    rst = r; train_en = t; dv_in = d; q_in = q;
    if (r) begin
      sb.delete();
      exp_data = '0;
    end else if (d) begin
      sb.push_back(q);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) exp_data = sb.pop_front();
    check("data_out", {28'd0, data_out}, {28'd0, exp_data});
  endtask

  function automatic vec_t mk(input logic r, input logic t, input logic d, input logic [3:0] q,
                              input logic a, input logic s, input logic e,
                              input logic [2:0] c, input logic o);
    vec_t v;
    v.rst = r; v.te = t; v.dv = d; v.q = q;
    v.aligned = a; v.slip = s; v.err = e; v.scnt = c; v.dvo = o;
    return v;
  endfunction

  // I_SERDES model: each slip rotates the received word right by one bit.
  function automatic logic [3:0] rotr(input logic [3:0] v, input int k);
    logic [3:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[0], r[3:1]};
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int n_rot;
    int last_pulse;
    int min_gap;
    int wide;
    logic prev;
    logic locked;
    logic seen;

    rst = 1'b1; train_en = 1'b0; dv_in = 1'b0; q_in = '0; exp_data = '0;

    // ---------------- table: lock, locked mismatch, valid gaps -------------
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 0));           // reset
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0));           // rise -> CHECK
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 1, 1, 4'h3, 0, 0, 0, 0, 0));         // matches 1..7
    vecs.push_back(mk(0, 1, 1, 4'h3, 1, 0, 0, 0, 1));           // match 8 -> lock
    vecs.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0));           // hold, no valid
    vecs.push_back(mk(0, 1, 1, 4'h5, !RELOCK, 0, 0, 0, !RELOCK)); // locked mismatch
    vecs.push_back(mk(0, 0, 0, 4'h0, !RELOCK, 0, 0, 0, 0));     // TRAIN_EN low
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0));           // re-rise clears
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 1, 4'h3, 0, 0, 0, 0, 0));         // matches 1..4
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 0, 0));         // valid gap
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 4'h3, 0, 0, 0, 0, 0));         // matches 5..7
    vecs.push_back(mk(0, 1, 1, 4'h3, 1, 0, 0, 0, 1));           // match 8 -> lock

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].te, vecs[i].dv, vecs[i].q);
      check($sformatf("vec%0d_aligned", i), {31'd0, aligned}, {31'd0, vecs[i].aligned});
      check($sformatf("vec%0d_bitslip", i), {31'd0, bitslip}, {31'd0, vecs[i].slip});
      check($sformatf("vec%0d_error", i), {31'd0, align_error}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_slip_cnt", i), {29'd0, slip_cnt}, {29'd0, vecs[i].scnt});
      check($sformatf("vec%0d_dv_out", i), {31'd0, dv_out}, {31'd0, vecs[i].dvo});
    end

    // ---------------- rotating input starting at 1100 -> two slips ---------
    cyc(1, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h0);
    n_rot = 0; pulses = 0; last_pulse = -100; min_gap = 1000; wide = 0;
    prev = 1'b0; locked = 1'b0;
    for (int c = 0; c < 200 && !locked; c++) begin
      cyc(0, 1, 1, rotr(4'b1100, n_rot));
      if (bitslip) begin
        if (prev) wide++;
        else begin
          pulses++;
          if (pulses > 1 && (c - last_pulse) < min_gap) min_gap = c - last_pulse;
          last_pulse = c;
        end
        n_rot++;
      end
      prev = bitslip;
      locked = aligned;
    end
    check("rot_locked", {31'd0, locked}, 32'd1);
    check("rot_pulses", pulses, 2);
    check("rot_pulse_width", wide, 0);
    check("rot_pulse_gap_ge5", {31'd0, (min_gap >= 5)}, 32'd1);
    check("rot_slip_cnt", {29'd0, slip_cnt}, 32'd2);
    check("rot_error", {31'd0, align_error}, 32'd0);

    // ---------------- constant 0000 -> four slips then FAIL ----------------
    cyc(1, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h0);
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      cyc(0, 1, 1, 4'h0);
      if (bitslip) pulses++;
    end
    check("fail_pulses", pulses, 4);
    check("fail_error", {31'd0, align_error}, 32'd1);
    check("fail_aligned", {31'd0, aligned}, 32'd0);
    check("fail_slip_cnt_sat", {29'd0, slip_cnt}, 32'd4);
    cyc(0, 0, 1, 4'h0);
    check("fail_error_held", {31'd0, align_error}, 32'd1);
    cyc(0, 1, 1, 4'h0);
    check("fail_rerise_error", {31'd0, align_error}, 32'd0);
    check("fail_rerise_slip_cnt", {29'd0, slip_cnt}, 32'd0);

    // ---------------- reset while in WAIT ----------------------------------
    cyc(1, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc(0, 1, 1, 4'h0);
      seen = bitslip;
    end
    check("wait_reached", {31'd0, seen}, 32'd1);
    check("wait_slip_cnt", {29'd0, slip_cnt}, 32'd1);
    cyc(1, 1, 1, 4'h9);
    check("rst_bitslip", {31'd0, bitslip}, 32'd0);
    check("rst_aligned", {31'd0, aligned}, 32'd0);
    check("rst_error", {31'd0, align_error}, 32'd0);
    check("rst_slip_cnt", {29'd0, slip_cnt}, 32'd0);
    check("rst_dv_out", {31'd0, dv_out}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 0, 1, 4'h0);
      if (bitslip) pulses++;
    end
    check("rst_idle_no_pulse", pulses, 0);

    // ---------------- TRAIN_EN dropped while in SLIP -----------------------
    cyc(1, 0, 0, 4'h0);
    cyc(0, 1, 0, 4'h0);
    cyc(0, 1, 1, 4'h6);                       // mismatch -> SLIP
    check("abort_pre_bitslip", {31'd0, bitslip}, 32'd0);
    cyc(0, 0, 0, 4'h0);                       // SLIP with TRAIN_EN low -> IDLE
    check("abort_bitslip", {31'd0, bitslip}, 32'd0);
    check("abort_slip_cnt", {29'd0, slip_cnt}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, 0, 4'h0);
      if (bitslip) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
